// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch controller: owns the PC and the IF/ID register, and fetches
// from a variable-latency instruction memory over a req/ready handshake.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        PCWrite_i,
  input  logic        Flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o
);

  // state   | meaning
  // S_REQ   | request outstanding (or about to be issued right after reset)
  // S_HOLD  | response captured in buf while the pipeline is stalled
  // S_DRAIN | waiting out a fetch that a flush made stale
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        req;
  logic [31:0] buf_instr;
  logic        buf_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;

  logic        advance;
  logic [31:0] pc_inc;
  logic [31:0] flush_pc;

  assign advance  = ~Stall_i & PCWrite_i;
  assign pc_inc   = pc + 32'd4;
  assign flush_pc = branch_target_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      req        <= 1'b0;
      buf_instr  <= NOP_INSTR;
      buf_valid  <= 1'b0;
      ifid_pc    <= 32'd0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (Flush_i) begin
      pc         <= flush_pc;
      buf_valid  <= 1'b0;
      ifid_pc    <= 32'd0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      case (state)
        S_REQ: begin
          // A request still in flight must be drained before redirecting.
          if (req && !imem_ready_i) begin
            state <= S_DRAIN;
          end else begin
            state    <= S_REQ;
            req      <= 1'b1;
            req_addr <= flush_pc;
          end
        end
        S_HOLD: begin
          state    <= S_REQ;
          req      <= 1'b1;
          req_addr <= flush_pc;
        end
        S_DRAIN: begin
          if (imem_ready_i) begin
            state    <= S_REQ;
            req_addr <= flush_pc;
          end
        end
        default: begin
          state    <= S_REQ;
          req      <= 1'b1;
          req_addr <= flush_pc;
        end
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (!req) begin
            req      <= 1'b1;
            req_addr <= pc;
            if (advance) begin
              ifid_instr <= NOP_INSTR;
              ifid_valid <= 1'b0;
            end
          end else if (imem_ready_i) begin
            if (advance) begin
              ifid_pc    <= req_addr;
              ifid_instr <= imem_rdata_i;
              ifid_valid <= 1'b1;
              pc         <= pc_inc;
              req_addr   <= pc_inc;
            end else begin
              buf_instr <= imem_rdata_i;
              buf_valid <= 1'b1;
              req       <= 1'b0;
              state     <= S_HOLD;
            end
          end else if (advance) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (advance) begin
            if (buf_valid) begin
              ifid_pc    <= req_addr;
              ifid_instr <= buf_instr;
              ifid_valid <= 1'b1;
            end else begin
              ifid_instr <= NOP_INSTR;
              ifid_valid <= 1'b0;
            end
            buf_valid <= 1'b0;
            pc        <= pc_inc;
            req_addr  <= pc_inc;
            req       <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (advance) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end
          if (imem_ready_i) begin
            state    <= S_REQ;
            req_addr <= pc;
          end
        end
        default: begin
          state <= S_REQ;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = req_addr;
  assign pc_o         = pc;
  assign ifid_pc_o    = ifid_pc;
  assign ifid_instr_o = ifid_instr;
  assign ifid_valid_o = ifid_valid;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: a memory model answers requests, the
// stimulus queues per-cycle control records and a monitor checks IF/ID and PC.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        Stall_i, PCWrite_i, Flush_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o, ifid_pc_o, ifid_instr_o;
  logic        ifid_valid_o;

  fetch_stage_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Stall_i(Stall_i), .PCWrite_i(PCWrite_i),
    .Flush_i(Flush_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o),
    .ifid_valid_o(ifid_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        fl;
    logic        st;
    logic        pw;
    logic        rdy;
    logic [31:0] tgt;
  } rec_t;

  rec_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          lat_cfg = 1;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  int          n_valid = 0;
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: memory answers at the negedge, the control record is
  // queued for the monitor, and the task returns #2 after the following posedge.
  task automatic tick(input logic fl, input logic st, input logic pw,
                      input logic [31:0] tgt, input logic hold_on_rdy, output logic rdy_o);
    logic rdy;
    rec_t r;
    @(negedge clk_i);
    rdy = 1'b0;
    if (imem_req_o) begin
      if (mem_cnt == 0) mem_lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
      rdy = (mem_cnt == mem_lat - 1);
      mem_cnt = rdy ? 0 : mem_cnt + 1;
    end else begin
      mem_cnt = 0;
    end
    imem_ready_i    = rdy;
    imem_rdata_i    = rdy ? mem_word(imem_addr_o) : $urandom;
    Flush_i         = fl;
    Stall_i         = st | (hold_on_rdy & rdy);
    PCWrite_i       = pw & ~(hold_on_rdy & rdy);
    branch_target_i = tgt;
    r.fl = Flush_i; r.st = Stall_i; r.pw = PCWrite_i; r.rdy = rdy; r.tgt = tgt;
    sbq.push_back(r);
    rdy_o = rdy;
    @(posedge clk_i);
    #2;
  endtask

  // Monitor: architectural model of the instruction stream seen in IF/ID.
  rec_t        mr;
  logic        prev_req;
  logic [31:0] prev_addr, prev_pc, prev_ifid_pc, prev_instr;
  logic        prev_valid;

  always @(posedge clk_i) begin
    #1;
    if (sbq.size() != 0) begin
      mr = sbq.pop_front();
      if (prev_req && !mr.rdy) begin
        chk("req_held", imem_req_o, 1);
        chk("addr_stable", imem_addr_o, prev_addr);
      end
      if (imem_req_o) chk("addr_align", {30'd0, imem_addr_o[1:0]}, 0);
      if (mr.fl) begin
        exp_pc = mr.tgt & ~32'd3;
        chk("flush_valid", ifid_valid_o, 0);
        chk("flush_instr", ifid_instr_o, NOP_INSTR);
        chk("flush_ifid_pc", ifid_pc_o, 0);
        chk("flush_pc", pc_o, exp_pc);
      end else if (!(!mr.st && mr.pw)) begin
        chk("hold_pc", pc_o, prev_pc);
        chk("hold_ifid_pc", ifid_pc_o, prev_ifid_pc);
        chk("hold_instr", ifid_instr_o, prev_instr);
        chk("hold_valid", ifid_valid_o, prev_valid);
      end else if (ifid_valid_o) begin
        chk("instr_pc", ifid_pc_o, exp_pc);
        chk("instr_data", ifid_instr_o, mem_word(exp_pc));
        chk("instr_next_pc", pc_o, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_valid++;
      end else begin
        chk("bubble_instr", ifid_instr_o, NOP_INSTR);
        chk("bubble_pc", pc_o, prev_pc);
      end
    end
    prev_req     = imem_req_o;
    prev_addr    = imem_addr_o;
    prev_pc      = pc_o;
    prev_ifid_pc = ifid_pc_o;
    prev_instr   = ifid_instr_o;
    prev_valid   = ifid_valid_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        d, got;
    logic [31:0] pc_save, ifid_save;
    int          nv0;

    rst_i = 1'b0; Stall_i = 1'b0; PCWrite_i = 1'b1; Flush_i = 1'b0;
    branch_target_i = '0; imem_ready_i = 1'b0; imem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_ifid_pc", ifid_pc_o, 0);
    chk("rst_instr", ifid_instr_o, NOP_INSTR);
    chk("rst_valid", ifid_valid_o, 0);
    chk("rst_req", imem_req_o, 0);
    #1 rst_i = 1'b1;

    // zero-latency memory, free-running
    lat_cfg = 1;
    tick(0, 0, 1, 0, 0, d);
    chk("zl_pc0", pc_o, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(0, 0, 1, 0, 0, d);
      chk("zl_pc", pc_o, 4 * k);
      chk("zl_ifid_pc", ifid_pc_o, 4 * (k - 1));
      chk("zl_valid", ifid_valid_o, 1);
    end

    // three-cycle memory: two bubbles then an instruction
    lat_cfg = 3;
    for (int k = 0; k < 9; k++) begin
      tick(0, 0, 1, 0, 0, d);
      chk("lat3_valid", ifid_valid_o, (k % 3 == 2) ? 1 : 0);
    end

    // stall arrives together with a response
    got = 1'b0;
    pc_save = pc_o; ifid_save = ifid_pc_o;
    for (int i = 0; i < 10 && !got; i++) begin
      pc_save = pc_o; ifid_save = ifid_pc_o;
      tick(0, 0, 1, 0, 1, got);
    end
    chk("stall_rdy_seen", got, 1);
    chk("stall1_req", imem_req_o, 0);
    chk("stall1_pc", pc_o, pc_save);
    chk("stall1_ifid_pc", ifid_pc_o, ifid_save);
    tick(0, 1, 0, 0, 0, d);
    chk("stall2_req", imem_req_o, 0);
    chk("stall2_pc", pc_o, pc_save);
    tick(0, 0, 1, 0, 0, d);
    chk("release_valid", ifid_valid_o, 1);
    chk("release_ifid_pc", ifid_pc_o, pc_save);
    chk("release_instr", ifid_instr_o, mem_word(pc_save));
    chk("release_pc", pc_o, pc_save + 32'd4);
    tick(0, 0, 1, 0, 0, d);
    chk("release_once", ifid_valid_o, 0);

    // flush while a fetch of 0x10 is outstanding
    tick(1, 0, 1, 32'h10, 0, d);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (imem_req_o && imem_addr_o == 32'h10) got = 1'b1;
      else tick(0, 0, 1, 0, 0, d);
    end
    chk("fetch10_issued", got, 1);
    tick(0, 0, 1, 0, 0, d);
    tick(1, 0, 1, 32'h103, 0, d);
    chk("fl_valid", ifid_valid_o, 0);
    chk("fl_instr", ifid_instr_o, NOP_INSTR);
    chk("fl_pc", pc_o, 32'h100);
    chk("fl_drain_addr", imem_addr_o, 32'h10);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (imem_req_o && imem_addr_o == 32'h100) got = 1'b1;
      else begin
        tick(0, 0, 1, 0, 0, d);
        chk("drain_no_valid", ifid_valid_o, 0);
      end
    end
    chk("req_0x100", got, 1);

    // flush together with stall
    tick(1, 1, 0, 32'h2000, 0, d);
    chk("fs_pc", pc_o, 32'h2000);
    chk("fs_valid", ifid_valid_o, 0);
    chk("fs_instr", ifid_instr_o, NOP_INSTR);

    // PC wrap-around
    lat_cfg = 1;
    tick(1, 0, 1, 32'hFFFF_FFFC, 0, d);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(0, 0, 1, 0, 0, d);
      if (ifid_valid_o) got = 1'b1;
    end
    chk("wrap_seen", got, 1);
    chk("wrap_ifid_pc", ifid_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc", pc_o, 32'h0);

    // asynchronous reset in the middle of a request
    lat_cfg = 3;
    tick(0, 0, 1, 0, 0, d);
    chk("arst_pre_req", imem_req_o, 1);
    #1 rst_i = 1'b0;
    Flush_i = 1'b0; Stall_i = 1'b0; PCWrite_i = 1'b1; imem_ready_i = 1'b0;
    #1;
    chk("arst_pc", pc_o, RESET_PC);
    chk("arst_ifid_pc", ifid_pc_o, 0);
    chk("arst_instr", ifid_instr_o, NOP_INSTR);
    chk("arst_valid", ifid_valid_o, 0);
    chk("arst_req", imem_req_o, 0);
    @(posedge clk_i);
    #3;
    mem_cnt = 0;
    exp_pc = RESET_PC;
    rst_i = 1'b1;
    lat_cfg = 1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick(0, 0, 1, 0, 0, d);
      if (ifid_valid_o) got = 1'b1;
    end
    chk("arst_restart_seen", got, 1);
    chk("arst_restart_pc", ifid_pc_o, RESET_PC);

    // randomized controls and latencies against the stream model
    lat_cfg = 0;
    nv0 = n_valid;
    for (int i = 0; i < 400; i++) begin
      logic fl, st, pw;
      int   sel;
      fl  = ($urandom_range(0, 19) == 0);
      sel = int'($urandom_range(0, 7));
      st  = (sel == 0 || sel == 1);
      pw  = !(sel == 0 || sel == 2);
      tick(fl, st, pw, $urandom, 0, d);
    end
    chk("rand_progress", (n_valid - nv0 >= 20) ? 1 : 0, 1);

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
